program_loader: RTL
===================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter: MAX_WORDS, 16, highest legal word count and instruction-memory depth (address width 4).
REQ-002 SHALL have port: CLK  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: RST_N  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: RX_DATA  input  8  incoming byte.
REQ-005 SHALL have port: RX_VALID  input  1  RX_DATA valid; byte accepted when RX_VALID and RX_READY are both high on a rising edge.
REQ-006 SHALL have port: RX_READY  output  1  loader can accept a byte this cycle.
REQ-007 SHALL have port: CLEAR  input  1  synchronous abort/reload request.
REQ-008 SHALL have port: WA  output  4  instruction-memory write address.
REQ-009 SHALL have port: WD  output  15  instruction-memory write data.
REQ-010 SHALL have port: WE  output  1  instruction-memory write enable, one-cycle pulse per word.
REQ-011 SHALL have port: PC_ENABLE  output  1  CPU run enable.
REQ-012 SHALL have port: BUSY  output  1  load in progress (states HI, LO, WRITE).
REQ-013 SHALL have port: ERR  output  1  protocol error, sticky.

Function
REQ-014 SHALL implement states IDLE, HI, LO, WRITE, RUN, ERROR; all outputs registered.
REQ-015 SHALL accept, in IDLE, a count byte N; 1..MAX_WORDS -> store N, clear word index, go HI; 0 or >MAX_WORDS -> ERROR.
REQ-016 SHALL accept, in HI, the high byte; bit 7 = 0 -> hold bits 6:0 as WD[14:8], go LO; bit 7 = 1 -> ERROR.
REQ-017 SHALL accept, in LO, the low byte as WD[7:0] and go WRITE.
REQ-018 SHALL, in WRITE (exactly one cycle), drive WE=1 with WA = word index and the assembled WD; then increment index; go HI if index+1 < N, else RUN.
REQ-019 SHALL drive RX_READY=1 only in IDLE, HI, LO; WE=1 only in WRITE; PC_ENABLE=1 only in RUN; ERR=1 only in ERROR.
REQ-020 SHALL ignore RX_VALID when RX_READY=0; no byte is consumed in WRITE, RUN, ERROR.
REQ-021 SHALL write words to consecutive addresses 0..N-1; index never wraps (N<=16 guarantees last address 15).
REQ-022 SHALL, on CLEAR=1 in any state, go IDLE next cycle, drop PC_ENABLE/ERR/WE, discard partial word; CLEAR has priority over a simultaneous byte acceptance.
REQ-023 SHALL hold WA and WD stable from the WRITE cycle until the next WRITE (no glitching when WE=0).
REQ-024 SHALL remain in RUN or ERROR indefinitely until CLEAR or reset.
REQ-025 SHALL give throughput of one word per 3 cycles minimum (HI, LO, WRITE) with continuous RX_VALID.

Reset
REQ-026 SHALL, while RST_N=0, immediately force state IDLE, WA=0, WD=0, WE=0, PC_ENABLE=0, BUSY=0, ERR=0, RX_READY=0, index=0, N=0.
REQ-027 SHALL assert RX_READY=1 on the first rising edge after RST_N deasserts; reset mid-load abandons the load with no further WE.

Verification
REQ-028 SHALL pass: bytes 0x02,0x12,0x34,0x05,0x67 -> WE pulses WA=0 WD=0x1234, WA=1 WD=0x0567; PC_ENABLE=1 the cycle after the second WE.
REQ-029 SHALL pass: count byte 0x00 and separately 0x11 -> ERR=1, RX_READY=0, no WE; CLEAR -> ERR=0, IDLE.
REQ-030 SHALL pass: count 0x01, high byte 0x80 -> ERR=1, no WE.
REQ-031 SHALL pass: count 0x10, 16 words streamed with RX_VALID held high -> 16 WE pulses WA=0..15, 48+ cycles, then PC_ENABLE=1.
REQ-032 SHALL pass: CLEAR asserted in LO with RX_VALID=1 -> byte not consumed, no WE, IDLE next cycle; fresh load then succeeds.
REQ-033 SHALL pass: RST_N pulled low between two words -> outputs zero asynchronously, no WE; after release reload of count 0x01 writes WA=0.

Source files
------------

// File: rtl/program_loader_if.sv
// program_loader_if: byte-stream input and instruction-memory write bus of the program loader
//   rx_data/rx_valid/rx_ready : byte handshake into the loader
//   clear                     : synchronous abort/reload request
//   wa/wd/we                  : instruction-memory write port
//   pc_enable/busy/err        : CPU run enable, load-in-progress, sticky protocol error
interface program_loader_if #(parameter int AW = 4);
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          clear;
  logic [AW-1:0] wa;
  logic [14:0]   wd;
  logic          we;
  logic          pc_enable;
  logic          busy;
  logic          err;
  modport master(output rx_data, rx_valid, clear, input rx_ready, wa, wd, we, pc_enable, busy, err);
  modport slave(input rx_data, rx_valid, clear, output rx_ready, wa, wd, we, pc_enable, busy, err);
endinterface

// File: rtl/program_loader.sv
// program_loader: receives a count byte then count x (high, low) byte pairs and writes 15-bit words to instruction memory
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : program_loader_if.slave (byte handshake in, memory write port and status out)
module program_loader #(
  parameter int MAX_WORDS = 16
) (
  input logic            clk,
  input logic            rst_n,
  program_loader_if.slave bus
);
  localparam int AW = $clog2(MAX_WORDS);
  localparam logic [7:0] MAX_CNT = 8'(MAX_WORDS);
  typedef enum logic [2:0] {IDLE, HI, LO, WRITE, RUN, ERROR} state_t;
  state_t state, state_nx;
  logic [AW:0]   n;
  logic [AW:0]   idx_inc;
  logic [AW-1:0] idx;
  logic [6:0]    hi;
  logic          take;
  // clear wins over a byte offered in the same cycle
  assign take = bus.rx_valid & bus.rx_ready & ~bus.clear;
  assign idx_inc = {1'b0, idx} + 1'b1;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (take) state_nx = (bus.rx_data != 8'd0 && bus.rx_data <= MAX_CNT) ? HI : ERROR;
      HI:      if (take) state_nx = bus.rx_data[7] ? ERROR : LO;
      LO:      if (take) state_nx = WRITE;
      WRITE:   state_nx = (idx_inc < n) ? HI : RUN;
      default: state_nx = state;
    endcase
    if (bus.clear) state_nx = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // outputs are registered from the next state so they line up with the state they describe
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.rx_ready  <= 1'b0;
      bus.we        <= 1'b0;
      bus.pc_enable <= 1'b0;
      bus.busy      <= 1'b0;
      bus.err       <= 1'b0;
      bus.wa        <= '0;
      bus.wd        <= '0;
      n             <= '0;
      idx           <= '0;
      hi            <= '0;
    end else begin
      bus.rx_ready  <= state_nx inside {IDLE, HI, LO};
      bus.we        <= state_nx == WRITE;
      bus.pc_enable <= state_nx == RUN;
      bus.busy      <= state_nx inside {HI, LO, WRITE};
      bus.err       <= state_nx == ERROR;
      if (take && state == IDLE && state_nx == HI) begin
        n   <= bus.rx_data[AW:0];
        idx <= '0;
      end
      if (take && state == HI) hi <= bus.rx_data[6:0];
      // address and data change only when entering WRITE, so they stay put while we is low
      if (take && state == LO) begin
        bus.wa <= idx;
        bus.wd <= {hi, bus.rx_data};
      end
      // the index is bumped only when another word follows, so it never wraps
      if (state == WRITE && state_nx == HI) idx <= idx_inc[AW-1:0];
    end
endmodule
